// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the two-requester adder arbiter and its adder.
package adder_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ID_W   = 1;

    typedef logic [ID_W-1:0] req_id_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adder32bit.sv
// Combinational 32-bit add/subtract. en selects a - b by inverting b and adding en.
module adder32bit
    import adder_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              en,
    input  logic              carry_in,
    output logic [DATA_W-1:0] sum,
    output logic              carry_out,
    output logic              ovf
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   total;

    always_comb begin
        b_eff     = en ? ~b : b;
        total     = {1'b0, a} + {1'b0, b_eff}
                  + {{DATA_W{1'b0}}, en} + {{DATA_W{1'b0}}, carry_in};
        sum       = total[DATA_W-1:0];
        // For subtraction bit 32 is the inverted borrow, i.e. 1 when a >= b.
        carry_out = total[DATA_W];
        ovf       = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder between two requesters, one operation in flight.
module adder_arbiter
    import adder_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req0_sub,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req1_sub,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_carry,
    output logic              rsp0_ovf,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_carry,
    output logic              rsp1_ovf
);

    state_t            state_q, state_d;
    req_id_t           last_q, last_d;
    req_id_t           id_q, id_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              sub_q, sub_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;

    logic              grant_any;
    req_id_t           grant_id;
    logic              rsp_fire;
    logic [DATA_W-1:0] sum;
    logic              sum_carry;
    logic              sum_ovf;

    adder32bit u_adder (
        .a         (a_q),
        .b         (b_q),
        .en        (sub_q),
        .carry_in  (1'b0),
        .sum       (sum),
        .carry_out (sum_carry),
        .ovf       (sum_ovf)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        sub_d      = sub_q;
        data_d     = data_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        rsp_fire   = 1'b0;

        grant_any = req0_valid | req1_valid;
        // Under contention the requester not granted last time wins.
        if (req0_valid && req1_valid) begin
            grant_id = ~last_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end else begin
            grant_id = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    req0_ready = (grant_id == 1'b0);
                    req1_ready = (grant_id == 1'b1);
                    a_d        = (grant_id == 1'b1) ? req1_a   : req0_a;
                    b_d        = (grant_id == 1'b1) ? req1_b   : req0_b;
                    sub_d      = (grant_id == 1'b1) ? req1_sub : req0_sub;
                    id_d       = grant_id;
                    last_d     = grant_id;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                data_d  = sum;
                carry_d = sum_carry;
                ovf_d   = sum_ovf;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp0_valid = (id_q == 1'b0);
                rsp1_valid = (id_q == 1'b1);
                rsp_fire   = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);
                if (rsp_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            data_q  <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // Result registers are shared; only the matching rspN_valid qualifies them.
    assign rsp0_data  = data_q;
    assign rsp0_carry = carry_q;
    assign rsp0_ovf   = ovf_q;
    assign rsp1_data  = data_q;
    assign rsp1_carry = carry_q;
    assign rsp1_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter: arithmetic, arbitration, backpressure, reset.
module tb_adder_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp0_carry, rsp0_ovf;
    logic [31:0] rsp0_data;
    logic        rsp1_valid, rsp1_ready, rsp1_carry, rsp1_ovf;
    logic [31:0] rsp1_data;

    int total = 0;
    int bad   = 0;

    adder_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sub   (req0_sub),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sub   (req1_sub),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_carry (rsp0_carry),
        .rsp0_ovf   (rsp0_ovf),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_carry (rsp1_carry),
        .rsp1_ovf   (rsp1_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-requester operation with response ready high; entered and left in IDLE.
    task automatic do_op(input string tag, input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] ed, input logic ec, input logic eo);
        if (id == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
        end
        #1;
        chk({tag, "_ready0"}, 32'(req0_ready), 32'(id == 0));
        chk({tag, "_ready1"}, 32'(req1_ready), 32'(id == 1));
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_exec_vld0"}, 32'(rsp0_valid), 32'd0);
        chk({tag, "_exec_vld1"}, 32'(rsp1_valid), 32'd0);
        tick();
        chk({tag, "_vld0"}, 32'(rsp0_valid), 32'(id == 0));
        chk({tag, "_vld1"}, 32'(rsp1_valid), 32'(id == 1));
        chk({tag, "_data"}, (id == 0) ? rsp0_data : rsp1_data, ed);
        chk({tag, "_carry"}, 32'((id == 0) ? rsp0_carry : rsp1_carry), 32'(ec));
        chk({tag, "_ovf"}, 32'((id == 0) ? rsp0_ovf : rsp1_ovf), 32'(eo));
        $display("op %s id=%0d a=0x%08h b=0x%08h sub=%0d -> data=0x%08h", tag, id, a, b, sub, ed);
        tick();
        chk({tag, "_done_vld"}, 32'(rsp0_valid | rsp1_valid), 32'd0);
    endtask

    // One arbitration round with both requesters valid; entered and left in IDLE.
    task automatic round(input string tag, input int g, input logic [31:0] ed,
                         input logic ec, input logic eo);
        chk({tag, "_grant0"}, 32'(req0_ready), 32'(g == 0));
        chk({tag, "_grant1"}, 32'(req1_ready), 32'(g == 1));
        tick();
        chk({tag, "_exec_rdy"}, 32'(req0_ready | req1_ready), 32'd0);
        tick();
        chk({tag, "_vld0"}, 32'(rsp0_valid), 32'(g == 0));
        chk({tag, "_vld1"}, 32'(rsp1_valid), 32'(g == 1));
        chk({tag, "_data"}, (g == 0) ? rsp0_data : rsp1_data, ed);
        chk({tag, "_carry"}, 32'((g == 0) ? rsp0_carry : rsp1_carry), 32'(ec));
        chk({tag, "_ovf"}, 32'((g == 0) ? rsp0_ovf : rsp1_ovf), 32'(eo));
        $display("round %s grant=%0d data=0x%08h", tag, g, ed);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_vld0", 32'(rsp0_valid), 32'd0);
        chk("rst_vld1", 32'(rsp1_valid), 32'd0);
        chk("rst_data", rsp0_data, 32'd0);
        chk("rst_carry", 32'(rsp0_carry), 32'd0);
        chk("rst_ovf", 32'(rsp1_ovf), 32'd0);
        $display("reset state checked");

        // Contention from reset: 10+20 for req0, 100-1 for req1
        req0_valid = 1'b1; req0_a = 32'd10;  req0_b = 32'd20; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd1;  req1_sub = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        round("cont1", 0, 32'd30, 1'b0, 1'b0);
        round("cont2", 1, 32'd99, 1'b1, 1'b0);
        round("cont3", 0, 32'd30, 1'b0, 1'b0);
        round("cont4", 1, 32'd99, 1'b1, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Single-requester arithmetic
        do_op("add5p3",   0, 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0);
        do_op("sub3m5",   1, 32'd3,         32'd5,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("sub5m3",   1, 32'd5,         32'd3,         1'b1, 32'h0000_0002, 1'b1, 1'b0);
        do_op("addwrap",  0, 32'hFFFF_FFFF, 32'd1,         1'b0, 32'h0000_0000, 1'b1, 1'b0);
        do_op("addovf",   0, 32'h7FFF_FFFF, 32'd1,         1'b0, 32'h8000_0000, 1'b0, 1'b1);
        do_op("subovf",   1, 32'h8000_0000, 32'd1,         1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

        // Backpressure on rsp0 with req1 waiting; req0 operands change after accept
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd3; req1_sub = 1'b1;
        #1;
        chk("bp_grant0", 32'(req0_ready), 32'd1);
        chk("bp_grant1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        req0_a = 32'hDEAD_BEEF;
        req0_b = 32'h1234_5678;
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_vld0", 32'(rsp0_valid), 32'd1);
            chk("bp_vld1", 32'(rsp1_valid), 32'd0);
            chk("bp_data", rsp0_data, 32'd3);
            chk("bp_rdy", 32'(req0_ready | req1_ready), 32'd0);
            tick();
        end
        $display("backpressure held 10 cycles");
        rsp0_ready = 1'b1;
        tick();
        chk("bp_after_vld0", 32'(rsp0_valid), 32'd0);
        chk("bp_resume_rdy1", 32'(req1_ready), 32'd1);
        chk("bp_resume_rdy0", 32'(req0_ready), 32'd0);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("bp_r1_vld", 32'(rsp1_valid), 32'd1);
        chk("bp_r1_data", rsp1_data, 32'd4);
        chk("bp_r1_carry", 32'(rsp1_carry), 32'd1);
        chk("bp_r1_ovf", 32'(rsp1_ovf), 32'd0);
        $display("post-backpressure req1 7-3 -> 0x%08h", 32'd4);
        tick();

        // Reset during EXEC of a req0 operation
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; req0_sub = 1'b0;
        #1;
        chk("mr_acc0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_vld0", 32'(rsp0_valid), 32'd0);
        chk("mr_vld1", 32'(rsp1_valid), 32'd0);
        chk("mr_data", rsp0_data, 32'd0);
        chk("mr_carry", 32'(rsp1_carry), 32'd0);
        tick();
        tick();
        chk("mr_hold_vld", 32'(rsp0_valid | rsp1_valid), 32'd0);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2; req0_sub = 1'b0;
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_sub = 1'b0;
        #1;
        round("mr_cont", 0, 32'd4, 1'b0, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 The block SHALL provide req0_valid input 1, requester 0 has an operation pending.
REQ-003 The block SHALL provide req0_ready output 1, requester 0 operation is accepted this cycle.
REQ-004 The block SHALL provide req0_a input 32, req0_b input 32 and req0_sub input 1: operands and op select for requester 0, where 0=add and 1=a-b.
REQ-005 The block SHALL provide req1_valid, req1_ready, req1_a, req1_b and req1_sub, identical to REQ-002..004 for requester 1.
REQ-006 The block SHALL provide rsp0_valid output 1, rsp0_ready input 1, rsp0_data output 32, rsp0_carry output 1 and rsp0_ovf output 1: response channel for requester 0.
REQ-007 The block SHALL provide rsp1_valid, rsp1_ready, rsp1_data, rsp1_carry and rsp1_ovf, identical to REQ-006 for requester 1.

Function
REQ-008 The block SHALL share one 32-bit adder between the two requesters and keep at most one operation in flight.
REQ-009 The FSM SHALL have the states IDLE, EXEC and RESP.
REQ-010 In IDLE, when at least one reqN_valid is high, the FSM SHALL grant exactly one requester, assert only that reqN_ready combinationally in the same cycle, capture its a, b, sub and id into registers, and move to EXEC.
REQ-011 reqN_ready SHALL be low in EXEC and RESP, and low in IDLE for the requester that is not granted.
REQ-012 Arbitration SHALL be round-robin: when both requesters are valid, the one not granted last wins, and a single valid requester always wins.
REQ-013 The last-grant register SHALL reset to 1, so requester 0 wins the first contention.
REQ-014 In EXEC (exactly one cycle), the FSM SHALL register the adder sum, carry and signed overflow into the response registers and move to RESP.
REQ-015 In RESP, rspN_valid SHALL be high only for the captured id, and rspN_data, rspN_carry and rspN_ovf SHALL be held stable until rspN_ready is high.
REQ-016 In RESP, on rspN_valid & rspN_ready, the FSM SHALL return to IDLE, and a new grant SHALL be possible no earlier than the next cycle.
REQ-017 The result SHALL be valid no earlier than two edges after acceptance: accept at edge E0, result captured at E1, rspN_valid high after E1.
REQ-018 Add SHALL compute data = (a+b) mod 2^32 with carry = bit 32 of the sum.
REQ-019 Sub SHALL compute data = (a + ~b + 1) mod 2^32 with carry = 1 when a>=b unsigned, i.e. no borrow.
REQ-020 ovf SHALL equal (a[31]==b'[31]) && (data[31]!=a[31]), where b' = b for add and ~b for sub.
REQ-021 With rspN_ready held low, the block SHALL stall in RESP indefinitely and accept nothing.
REQ-022 reqN_valid dropping while not granted SHALL leave no state behind, and operands SHALL be sampled only on the accept cycle.
REQ-023 rsp0_valid and rsp1_valid SHALL never both be high.

Reset
REQ-024 On rst_n low, asynchronously: FSM=IDLE, last-grant=1, all rspN_valid=0, rspN_data=0, rspN_carry=0, rspN_ovf=0, operand registers=0.
REQ-025 Reset asserted in EXEC or RESP SHALL discard the in-flight operation with no response issued.
REQ-026 After reset release, the first accept SHALL be possible in the first cycle with rst_n high.

Structure
REQ-027 The shared package SHALL hold the FSM state enum (IDLE/EXEC/RESP), the data width constant (32) and the requester-id width/type.
REQ-028 The single sub-module SHALL be adder32bit, instantiated once with en=captured sub and carry_in tied 0, since en alone supplies the +1 for subtraction.
REQ-029 Arbitration, the FSM and the response registers SHALL live in adder_arbiter, with no further sub-modules.

Verification
REQ-030 Single add: req0 a=0x0000_0005, b=0x0000_0003, sub=0, rsp0_ready=1 -> rsp0_valid two edges after accept, data=0x0000_0008, carry=0, ovf=0.
REQ-031 Sub with borrow: req1 a=3, b=5, sub=1 -> rsp1 data=0xFFFF_FFFE, carry=0, ovf=0; then a=5, b=3 -> data=2, carry=1.
REQ-032 Wrap/overflow: a=0xFFFF_FFFF, b=1, add -> data=0, carry=1, ovf=0; a=0x7FFF_FFFF, b=1, add -> data=0x8000_0000, carry=0, ovf=1.
REQ-033 Contention: both valid continuously from reset with distinct operands -> grants alternate 0,1,0,1, and each rsp carries its own requester's result.
REQ-034 Backpressure: rsp0_ready low for 10 cycles -> rsp0_valid and data stable, both reqN_ready low throughout, accept resumes the cycle after the handshake.
REQ-035 Reset mid-EXEC: assert rst_n low during EXEC -> no rsp_valid, outputs zero, and the next contention grants req0.
